// File: rtl/ifu_pkg.sv
// ifu_pkg: shared state encoding, defaults and buffer entry layout for the instruction fetch unit
package ifu_pkg;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
    localparam int ADDR_W_DEFAULT = 64;
    localparam int INST_W_DEFAULT = 32;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetchState_t;

    typedef struct packed {
        logic [ADDR_W_DEFAULT-1:0] pc;
        logic [INST_W_DEFAULT-1:0] inst;
        logic                      fault;
    } fetchEntry_t;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous power-of-two FIFO of fetch entries; flush overrides push and pop
module ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 96
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr;

    assign head = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= din;
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop)
                rdPtr <= rdPtr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: fetch PC owner, single-outstanding imem requester and instruction buffer for decode.
// Define IFU_ALIGN_CHECK_EN to turn misaligned redirect targets into faulting entries on inst_fault.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int INST_W = INST_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [INST_W-1:0] mem_resp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
`ifdef IFU_ALIGN_CHECK_EN
    output logic              inst_fault,
`endif
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef IFU_ALIGN_CHECK_EN
    localparam int EW = ADDR_W + INST_W + 1;
`else
    localparam int EW = ADDR_W + INST_W;
`endif

    fetchState_t state, stateNext, resume;
    logic [ADDR_W-1:0] pc, reqPc, redirTarget;
    logic [CW-1:0] count, postCount;
    logic [EW-1:0] pushData, head;
    logic push, pop, halt, haltNext, faultPush;

`ifdef IFU_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = redirect_pc[1:0] != 2'b00;
    assign redirTarget = redirect_pc;
    assign haltNext = redirect_valid ? misaligned : halt;
    assign pushData = faultPush ? {pc, INST_W'(0), 1'b1} : {reqPc, mem_resp_data, 1'b0};
    assign {inst_pc, inst, inst_fault} = head;
    // A misaligned target parks fetch and queues one faulting entry the cycle after the flush.
    always_ff @(posedge clk) begin
        halt <= !rst && haltNext;
        faultPush <= !rst && redirect_valid && misaligned;
    end
`else
    logic unusedLowBits;
    assign unusedLowBits = ^redirect_pc[1:0];
    assign redirTarget = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign halt = 1'b0;
    assign haltNext = 1'b0;
    assign faultPush = 1'b0;
    assign pushData = {reqPc, mem_resp_data};
    assign {inst_pc, inst} = head;
`endif

    assign inst_valid = count != '0;
    assign pop = inst_valid && inst_ready;
    assign push = (state == WAIT && mem_resp_valid && !redirect_valid) || faultPush;
    assign postCount = count + CW'(push) - CW'(pop);
    assign resume = haltNext ? IDLE : REQ;

    ifu_fifo #(.DEPTH(FIFO_DEPTH), .W(EW)) fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(redirect_valid),
        .din(pushData),
        .head(head),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            reqPc <= RESET_PC;
        end else begin
            state <= stateNext;
            if (redirect_valid)
                pc <= redirTarget;
            else if (mem_req_valid && mem_req_ready) begin
                reqPc <= pc;
                pc <= pc + ADDR_W'(4);
            end
        end
    end

    // An accepted-but-unanswered request under redirect must have its response swallowed in DROP.
    always_comb begin
        stateNext = state;
        if (redirect_valid)
            stateNext = ((state == REQ && mem_req_ready) || ((state == WAIT || state == DROP) && !mem_resp_valid)) ? DROP : resume;
        else if (state == IDLE)
            stateNext = (count < CW'(FIFO_DEPTH) && !halt) ? REQ : IDLE;
        else if (state == REQ)
            stateNext = mem_req_ready ? WAIT : REQ;
        else if (state == WAIT)
            stateNext = !mem_resp_valid ? WAIT : (postCount < CW'(FIFO_DEPTH) ? REQ : IDLE);
        else
            stateNext = mem_resp_valid ? resume : DROP;
    end

    always_comb begin
        mem_req_valid = state == REQ;
        mem_req_addr = pc;
    end
endmodule
